// File: rtl/ntt_delay_sched_if.sv
// ntt_delay_sched_if: control/status bundle between the NTT top-level
// control, the shared delay RAM and the delay-line sequencer.
// Optional port: inverse (only with NTT_DELAY_INV_EN defined).
// master: drives start/in_valid(/inverse), observes schedule outputs.
// slave : the sequencer, drives busy/done/stage/addr/ram_we/
//         out_valid/pair_hi.
interface ntt_delay_sched_if #(
  parameter int STAGES    = 8,
  parameter int MAX_DELAY = 128
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic          start;
  logic          in_valid;
`ifdef NTT_DELAY_INV_EN
  logic          inverse;
`endif
  logic          busy;
  logic          done;
  logic [SW-1:0] stage;
  logic [AW-1:0] addr;
  logic          ram_we;
  logic          out_valid;
  logic          pair_hi;

`ifdef NTT_DELAY_INV_EN
  modport master (
    output start, in_valid, inverse,
    input  busy, done, stage, addr,
    input  ram_we, out_valid, pair_hi
  );
  modport slave (
    input  start, in_valid, inverse,
    output busy, done, stage, addr,
    output ram_we, out_valid, pair_hi
  );
`else
  modport master (
    output start, in_valid,
    input  busy, done, stage, addr,
    input  ram_we, out_valid, pair_hi
  );
  modport slave (
    input  start, in_valid,
    output busy, done, stage, addr,
    output ram_we, out_valid, pair_hi
  );
`endif
endinterface

// File: rtl/ntt_delay_sched.sv
// ntt_delay_sched: runs the single-port delay RAM as a delay line whose
// length D(stage) halves per NTT stage (doubles in inverse mode).
// Ports: clk, rst (async, active high), bus (ntt_delay_sched_if.slave):
//   start/in_valid in; busy, done, stage, addr, ram_we, out_valid,
//   pair_hi out. Macro NTT_DELAY_INV_EN adds bus.inverse (INTT order).
module ntt_delay_sched #(
  parameter int N         = 256,
  parameter int STAGES    = 8,
  parameter int MAX_DELAY = 128
) (
  input  logic                clk,
  input  logic                rst,
  ntt_delay_sched_if.slave    bus
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int CW = $clog2(N);
  localparam int DW = AW + 1;
  localparam int OW = CW + 1;

  localparam logic [DW-1:0] DMAX = DW'(MAX_DELAY);
`ifdef NTT_DELAY_INV_EN
  localparam logic [DW-1:0] DMIN = DW'(MAX_DELAY >> (STAGES - 1));
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [OW-1:0] oidx_q, oidx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          outv_q, outv_d;
  logic          pair_q, pair_d;
`ifdef NTT_DELAY_INV_EN
  logic          inv_q, inv_d;
`endif

  logic [DW-1:0] dly;
  logic          we;
  logic          last_addr;
  logic          is_out;

  always_comb begin
`ifdef NTT_DELAY_INV_EN
    dly = inv_q ? (DMIN << stage_q) : (DMAX >> stage_q);
`else
    dly = DMAX >> stage_q;
`endif
  end

  assign we = ((state_q == RUN) && bus.in_valid) ||
              (state_q == FLUSH);
  assign last_addr = ({1'b0, addr_q} == (dly - 1'b1));
  // Once the line is full every access reads back a delayed value.
  assign is_out = (fill_q == dly);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    oidx_d  = oidx_q;
`ifdef NTT_DELAY_INV_EN
    inv_d   = inv_q;
`endif
    outv_d  = we && is_out;
    // D is a power of two: masking with D picks bit log2(D).
    pair_d  = we && is_out && (|(oidx_q & OW'(dly)));

    if (we) begin
      addr_d = last_addr ? '0 : addr_q + 1'b1;
      if (is_out) begin
        oidx_d = oidx_q + 1'b1;
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          stage_d = '0;
          addr_d  = '0;
          cnt_d   = '0;
          fill_d  = '0;
          oidx_d  = '0;
`ifdef NTT_DELAY_INV_EN
          inv_d   = bus.inverse;
`endif
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // N is a multiple of D, so the flush starts at addr 0
        // and its last access is the one at addr D-1.
        if (last_addr) begin
          if (stage_q == SW'(STAGES - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            addr_d  = '0;
            cnt_d   = '0;
            fill_d  = '0;
            oidx_d  = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      oidx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      outv_q  <= 1'b0;
      pair_q  <= 1'b0;
`ifdef NTT_DELAY_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      oidx_q  <= oidx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      outv_q  <= outv_d;
      pair_q  <= pair_d;
`ifdef NTT_DELAY_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.addr      = addr_q;
  assign bus.ram_we    = we;
  assign bus.out_valid = outv_q;
  assign bus.pair_hi   = pair_q;

endmodule

// File: tb/tb_ntt_delay_sched.sv
// tb_ntt_delay_sched: directed bench for ntt_delay_sched.
// Expected pair_hi values are queued per access and popped next cycle.
module tb_ntt_delay_sched;
  localparam int N      = 256;
  localparam int STAGES = 8;
  localparam int MAXD   = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_delay_sched_if #(
    .STAGES(STAGES),
    .MAX_DELAY(MAXD)
  ) bus ();

  ntt_delay_sched #(
    .N(N),
    .STAGES(STAGES),
    .MAX_DELAY(MAXD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int outs  = 0;
  int accs  = 0;
  bit q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called once per cycle at negedge: an output is due exactly one
  // cycle after each queued access.
  task automatic chk_out();
    bit e;
    bit p;
    e = (q.size() > 0);
    chk("out_valid", bus.out_valid, e);
    if (e) begin
      p = q.pop_front();
      chk("pair_hi", bus.pair_hi, p);
    end
    if (bus.out_valid === 1'b1) outs++;
    if (bus.ram_we === 1'b1) accs++;
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {bus.busy, bus.done, bus.ram_we, bus.out_valid,
              bus.pair_hi, 24'(bus.stage), 24'(bus.addr)}, 0);
  endtask

  task automatic do_start();
    outs = 0;
    accs = 0;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk_out();
    chk("start_idle_busy", bus.busy, 0);
    chk("start_idle_we", bus.ram_we, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_stage(input int s, input int d, input int lim,
                           input bit tog, input bit st);
    int k = 0;
    int acc = 0;
    int c = 0;
    bit iv;
    while (acc < lim) begin
      iv = tog ? (c % 2 == 0) : 1'b1;
      bus.in_valid = iv;
      bus.start = st;
      @(negedge clk);
      chk_out();
      chk("stage", bus.stage, s);
      chk("busy", bus.busy, 1);
      chk("ram_we", bus.ram_we, iv);
      if (iv) begin
        chk("addr", bus.addr, k % d);
        if (k >= d) q.push_back(((k - d) / d) % 2 == 1);
        k++;
        acc++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    bus.start = 1'b0;
    if (lim == N) begin
      bus.in_valid = tog;
      for (int f = 0; f < d; f++) begin
        @(negedge clk);
        chk_out();
        chk("flush_we", bus.ram_we, 1);
        chk("flush_addr", bus.addr, f);
        chk("flush_stage", bus.stage, s);
        chk("flush_busy", bus.busy, 1);
        q.push_back(((k - d) / d) % 2 == 1);
        k++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic end_pass();
    @(negedge clk);
    chk_out();
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_we", bus.ram_we, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_out();
    chk("done_once", bus.done, 0);
    chk("pass_outs", outs, N * STAGES);
    chk("pass_accs", accs, N * STAGES + MAXD * 2 - 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
`ifdef NTT_DELAY_INV_EN
    bus.inverse = 1'b0;
`endif
    // Reset and idle behaviour.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    all_zero("reset_outs");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk_out();
      all_zero("idle_outs");
      @(posedge clk);
      #1;
    end

    // Pass 1: continuous input, all stages.
    do_start();
    for (int s = 0; s < STAGES; s++) begin
      run_stage(s, MAXD >> s, N, 1'b0, 1'b0);
    end
    end_pass();

    // Pass 2: start held while busy, gapped stage 2, reset in stage 3.
    do_start();
    run_stage(0, MAXD, N, 1'b0, 1'b1);
    run_stage(1, MAXD >> 1, N, 1'b0, 1'b0);
    run_stage(2, MAXD >> 2, N, 1'b1, 1'b0);
    run_stage(3, MAXD >> 3, 40, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    all_zero("midpass_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pass 3: restart begins at stage 0 with the full schedule.
    do_start();
    run_stage(0, MAXD, N, 1'b0, 1'b0);
    @(negedge clk);
    chk_out();
    chk("restart_stage1", bus.stage, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef NTT_DELAY_INV_EN
    // Inverse pass: inverse only matters on the accepted start.
    bus.inverse = 1'b1;
    do_start();
    bus.inverse = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      run_stage(s, (MAXD >> (STAGES - 1)) << s, N, 1'b0, 1'b0);
    end
    end_pass();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ntt_delay_sched.md
Name: ntt_delay_sched

Overview:
- Sequencer for the shared single-port delay RAM (`sio_ram`: read-before-write, registered output) in the NTT datapath.
- Runs the RAM as a variable-length delay line across all NTT stages: generates addresses, write strobes and output-valid flags.
- Stage delay halves each stage so butterfly pairs line up at distance D(stage).
- Sits between the NTT top-level control (start/done handshake) and the RAM plus butterfly input mux.

Parameters:
- N, 256, coefficients per polynomial pass; power of two.
- STAGES, 8, number of NTT stages per pass.
- MAX_DELAY, 128, delay of stage 0 in RAM accesses; power of two. MAX_DELAY>>(STAGES-1) must be >= 1.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin a pass; sampled in IDLE only
- in_valid  input  1  coefficient present at RAM input this cycle
- busy  output  1  pass in progress (RUN or FLUSH)
- done  output  1  one-cycle pulse at end of pass
- stage  output  $clog2(STAGES)  current stage index
- addr  output  $clog2(MAX_DELAY)  RAM address
- ram_we  output  1  RAM access this cycle
- out_valid  output  1  RAM out carries a delayed coefficient this cycle
- pair_hi  output  1  butterfly select, registered alongside out_valid

Behaviour:
- Reset (async, any state): state=IDLE; stage, addr, coefficient counter, fill counter = 0; busy, done, ram_we, out_valid, pair_hi = 0.
- D(s) = MAX_DELAY>>s.
- An access is any cycle with ram_we=1. addr wraps modulo D(stage): 0..D-1, 0, ...; addr advances after each access. When D=1, addr stays 0.
- States:
  - IDLE: busy=0. start=1 → RUN next cycle, with stage=0 and all counters cleared.
  - RUN: ram_we = in_valid (combinational); in_valid=0 holds all counters. Coefficient counter cnt counts accepted inputs. The access with cnt=N-1 → FLUSH.
  - FLUSH: ram_we=1 every cycle, for exactly D(stage) accesses; RAM write data is don't-care. After the last flush access:
    - if stage<STAGES-1: stage++, addr/cnt/fill cleared, → RUN with no bubble cycle.
    - otherwise → DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then → IDLE.
- Fill counter counts accesses in the current stage, saturating at D.
- out_valid is registered: out_valid(t+1) = ram_we(t) && fill(t)==D. This gives exactly N out_valid pulses per stage.
- pair_hi(t+1) = bit log2(D) of the stage output index for the access at t. It is 0 for the first D outputs and toggles every D outputs.
- Transition overlap:
  - The last out_valid of a stage falls in the first cycle of the next stage's RUN.
  - In the final stage it coincides with done.
- start while busy or in DONE: ignored.
- in_valid outside RUN: ignored; no access, no counter change.
- Reset mid-pass: all state discarded; the next start begins at stage 0.

Optional Feature:
- Macro: NTT_DELAY_INV_EN.
- Defined:
  - Adds input port `inverse` (1 bit), sampled on the accepted start and held for the pass.
  - inverse=1 gives D(s) = (MAX_DELAY>>(STAGES-1))<<s, i.e. 1, 2, ... 128 for the INTT ordering.
  - inverse=0 keeps the forward schedule.
- Undefined: port absent; forward schedule only.

Test Plan:
1. Assert rst mid-idle, then release → all outputs 0, state IDLE. Hold start=0 for 10 cycles → outputs stay 0.
2. start, then in_valid=1 continuous for stage 0 →
   - addr runs 0..127 and wraps to 0 on access 128;
   - first out_valid one cycle after access 128, with pair_hi=0;
   - pair_hi flips to 1 after 128 outputs;
   - 256 out_valid pulses in the stage;
   - FLUSH lasts 128 cycles;
   - stage=1 on the next cycle.
3. Full pass with continuous in_valid → 2303 accesses total (8×256 + 255 flush).
   - done pulses once, on the cycle after the final access, coincident with the 2048th out_valid;
   - busy drops in the same cycle.
4. in_valid toggling 1,0,1,0 in stage 2 (D=32) → addr and counters frozen on 0 cycles; still exactly 256 out_valid; flush still 32 cycles.
5. rst pulsed during stage 3 RUN → all outputs 0 the same cycle. A new start gives stage=0, addr=0 and the full 256-cycle stage-0 schedule. start pulsed while busy → no effect.
6. With NTT_DELAY_INV_EN defined and inverse=1 → stage 0 D=1 (addr constant 0, first out_valid after access 1, pair_hi toggles every output); stage 7 D=128.
